// File: rtl/ball_fsm_if.sv
// Ball block bus: event/strobe inputs from collision logic, ball state out to collision and renderer.
interface ball_fsm_if;
    localparam int unsigned POS_W  = 10;
    localparam int unsigned SIZE_W = 8;

    logic              frame_tick;
    logic [1:0]        bounce;
    logic [POS_W-1:0]  ball_pos_x;
    logic [POS_W-1:0]  ball_pos_y;
    logic [SIZE_W-1:0] ball_size_x;
    logic [SIZE_W-1:0] ball_size_y;
    logic              dir_x;
    logic              dir_y;
    logic              serving;

    // Collision/scoring side: produces strobes and bounce codes, consumes ball state.
    modport master (
        output frame_tick, bounce,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, dir_x, dir_y, serving
    );

    // Ball owner side.
    modport slave (
        input  frame_tick, bounce,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, dir_x, dir_y, serving
    );
endinterface

// File: rtl/ball_fsm.sv
// Ball owner: serve delay at centre, then per-frame motion with idempotent bounce handling and edge clamping.
module ball_fsm #(
    parameter int unsigned SCREEN_X     = 640,
    parameter int unsigned SCREEN_Y     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned SPEED_X      = 2,
    parameter int unsigned SPEED_Y      = 2,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic     clock,
    input  logic     reset,
    ball_fsm_if.slave bus
);
    localparam int unsigned POS_W  = 10;
    localparam int unsigned SIZE_W = 8;
    localparam int unsigned CNT_W  = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [POS_W-1:0] CX     = POS_W'((SCREEN_X - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] CY     = POS_W'((SCREEN_Y - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0] MAX_X  = POS_W'(SCREEN_X - BALL_SIZE);
    localparam logic [POS_W-1:0] MAX_Y  = POS_W'(SCREEN_Y - BALL_SIZE);
    localparam logic [POS_W-1:0] HALF_X = POS_W'(SCREEN_X / 2);
    localparam logic [POS_W-1:0] HALF_Y = POS_W'(SCREEN_Y / 2);
    localparam logic [POS_W-1:0] STEP_X = POS_W'(SPEED_X);
    localparam logic [POS_W-1:0] STEP_Y = POS_W'(SPEED_Y);
    // Highest position from which a full positive step still fits on screen.
    localparam logic [POS_W-1:0] LIM_X  = POS_W'(SCREEN_X - BALL_SIZE - SPEED_X);
    localparam logic [POS_W-1:0] LIM_Y  = POS_W'(SCREEN_Y - BALL_SIZE - SPEED_Y);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [0:0] {
        SERVE = 1'b0,
        MOVE  = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [POS_W-1:0]   pos_x, pos_x_n;
    logic [POS_W-1:0]   pos_y, pos_y_n;
    logic               dx, dx_n;
    logic               dy, dy_n;
    logic [1:0]         prev_bounce;
    logic               serving_q;
    logic               score_evt;

    // Score is an edge on code 11, so a held code counts once.
    assign score_evt = (bus.bounce == 2'b11) && (prev_bounce != 2'b11);

    // State register and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SERVE;
            cnt         <= '0;
            pos_x       <= CX;
            pos_y       <= CY;
            dx          <= 1'b1;
            dy          <= 1'b1;
            prev_bounce <= 2'b00;
            serving_q   <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pos_x       <= pos_x_n;
            pos_y       <= pos_y_n;
            dx          <= dx_n;
            dy          <= dy_n;
            prev_bounce <= bus.bounce;
            serving_q   <= (state_n == SERVE);
        end
    end

    // Next-state: serve countdown, then score/paddle/wall/motion in priority order.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        dx_n    = dx;
        dy_n    = dy;

        case (state)
            SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        state_n = MOVE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end

            MOVE: begin
                if (score_evt) begin
                    pos_x_n = CX;
                    pos_y_n = CY;
                    dx_n    = ~dx;
                    cnt_n   = '0;
                    state_n = SERVE;
                end else begin
                    if (bus.bounce == 2'b01) begin
                        dx_n = (pos_x < HALF_X);
                    end else if (bus.bounce == 2'b10) begin
                        dy_n = (pos_y < HALF_Y);
                    end

                    if (bus.frame_tick) begin
                        if (dx_n) begin
                            pos_x_n = (pos_x > LIM_X) ? MAX_X : pos_x + STEP_X;
                        end else begin
                            pos_x_n = (pos_x < STEP_X) ? '0 : pos_x - STEP_X;
                        end
                        if (dy_n) begin
                            pos_y_n = (pos_y > LIM_Y) ? MAX_Y : pos_y + STEP_Y;
                        end else begin
                            pos_y_n = (pos_y < STEP_Y) ? '0 : pos_y - STEP_Y;
                        end
                    end
                end
            end

            default: begin
                state_n = SERVE;
            end
        endcase
    end

    assign bus.ball_pos_x  = pos_x;
    assign bus.ball_pos_y  = pos_y;
    assign bus.dir_x       = dx;
    assign bus.dir_y       = dy;
    assign bus.serving     = serving_q;
    assign bus.ball_size_x = SIZE_W'(BALL_SIZE);
    assign bus.ball_size_y = SIZE_W'(BALL_SIZE);
endmodule
